// File: rtl/maxpool_window_stream.sv
// Streaming max-pool over windows of configurable length.
// One element in per cycle; the window maximum is registered out with its element count.
module maxpool_window_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 4,
    parameter int SIGNED     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [CNT_W-1:0]      CFG_WIN_SIZE,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_FLUSH,
    output logic                  IN_READY,
    output logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    input  logic                  OUT_READY,
    output logic [CNT_W-1:0]      OUT_COUNT
);

    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] max_val;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      win;
    logic [CNT_W-1:0]      cfg_eff;
    logic [CNT_W-1:0]      cur_win;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  in_gt;
    logic                  accept;
    logic                  closing;

    // A held result stalls the input so nothing is lost downstream.
    assign IN_READY = !RESET && !(OUT_VALID && !OUT_READY);

    always_comb begin
        cfg_eff = (CFG_WIN_SIZE == '0) ? CNT_W'(1) : CFG_WIN_SIZE;
        cur_win = (cnt == '0) ? cfg_eff : win;
        cnt_inc = cnt + CNT_W'(1);
        if (SIGNED != 0)
            in_gt = $signed(IN_DATA) > $signed(acc);
        else
            in_gt = IN_DATA > acc;
        max_val = ((cnt == '0) || in_gt) ? IN_DATA : acc;
        accept  = IN_VALID && IN_READY;
        closing = accept && ((cnt_inc == cur_win) || IN_FLUSH);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            cnt       <= '0;
            win       <= CNT_W'(1);
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_COUNT <= '0;
        end else begin
            if (accept) begin
                acc <= max_val;
                if (cnt == '0)
                    win <= cfg_eff;
                if (closing) begin
                    OUT_DATA  <= max_val;
                    OUT_COUNT <= cnt_inc;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
            // A closing beat reloads the result on the same edge it is consumed.
            if (closing)
                OUT_VALID <= 1'b1;
            else if (OUT_READY)
                OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool_window_stream.sv
// Directed bench for maxpool_window_stream.
// A signed and an unsigned instance share the same stimulus.
module tb_maxpool_window_stream;

    logic        CLK;
    logic        RESET;
    logic [3:0]  CFG_WIN_SIZE;
    logic        IN_VALID;
    logic [15:0] IN_DATA;
    logic        IN_FLUSH;
    logic        OUT_READY;

    logic        s_ir, s_ov, u_ir, u_ov;
    logic [15:0] s_od, u_od;
    logic [3:0]  s_oc, u_oc;

    int vectors = 0;
    int errors  = 0;

    maxpool_window_stream #(.DATA_WIDTH(16), .CNT_W(4), .SIGNED(1)) dut_s (
        .CLK(CLK), .RESET(RESET), .CFG_WIN_SIZE(CFG_WIN_SIZE),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_FLUSH(IN_FLUSH),
        .IN_READY(s_ir), .OUT_VALID(s_ov), .OUT_DATA(s_od),
        .OUT_READY(OUT_READY), .OUT_COUNT(s_oc)
    );

    maxpool_window_stream #(.DATA_WIDTH(16), .CNT_W(4), .SIGNED(0)) dut_u (
        .CLK(CLK), .RESET(RESET), .CFG_WIN_SIZE(CFG_WIN_SIZE),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_FLUSH(IN_FLUSH),
        .IN_READY(u_ir), .OUT_VALID(u_ov), .OUT_DATA(u_od),
        .OUT_READY(OUT_READY), .OUT_COUNT(u_oc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic f);
        IN_VALID = v;
        IN_DATA  = d;
        IN_FLUSH = f;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        CFG_WIN_SIZE = 4'd4;
        OUT_READY = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        repeat (2) step();
        vectors++;
        if (s_ov !== 1'b0 || s_od !== 16'h0 || s_oc !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: got v=%b d=%h c=%h want 0/0000/0", s_ov, s_od, s_oc);
        end
        vectors++;
        if (s_ir !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", s_ir);
        end
        RESET = 1'b0;
        #1;
        vectors++;
        if (s_ir !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 1", s_ir);
        end
    endtask

    task automatic test_basic();
        logic [15:0] d [4];
        d[0] = 16'd3; d[1] = 16'hFFF9; d[2] = 16'd12; d[3] = 16'd5;
        CFG_WIN_SIZE = 4'd4;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i], 1'b0);
            step();
            if (i < 3) begin
                vectors++;
                if (s_ov !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid beat%0d: got %b want 0", i, s_ov);
                end
            end
        end
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd12 || s_oc !== 4'd4) begin
            errors++;
            $display("FAIL basic_result: got v=%b d=%h c=%0d want 1/000c/4", s_ov, s_od, s_oc);
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: got %b want 0", s_ov);
        end
    endtask

    task automatic test_signedness();
        CFG_WIN_SIZE = 4'd2;
        drive(1'b1, 16'h8000, 1'b0);
        step();
        drive(1'b1, 16'h0001, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'h0001) begin
            errors++;
            $display("FAIL signed_max: got v=%b d=%h want 1/0001", s_ov, s_od);
        end
        vectors++;
        if (u_ov !== 1'b1 || u_od !== 16'h8000) begin
            errors++;
            $display("FAIL unsigned_max: got v=%b d=%h want 1/8000", u_ov, u_od);
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_flush();
        CFG_WIN_SIZE = 4'd4;
        drive(1'b1, 16'd9, 1'b0);
        step();
        drive(1'b1, 16'd2, 1'b1);
        step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd9 || s_oc !== 4'd2) begin
            errors++;
            $display("FAIL flush_result: got v=%b d=%h c=%0d want 1/0009/2", s_ov, s_od, s_oc);
        end
        CFG_WIN_SIZE = 4'd2;
        drive(1'b1, 16'd1, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL flush_fresh_valid: got %b want 0", s_ov);
        end
        drive(1'b1, 16'd5, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd5 || s_oc !== 4'd2) begin
            errors++;
            $display("FAIL flush_fresh_result: got v=%b d=%h c=%0d want 1/0005/2", s_ov, s_od, s_oc);
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_backpressure();
        CFG_WIN_SIZE = 4'd2;
        OUT_READY = 1'b1;
        drive(1'b1, 16'd10, 1'b0);
        step();
        drive(1'b1, 16'd20, 1'b0);
        step();
        OUT_READY = 1'b0;
        drive(1'b1, 16'd30, 1'b0);
        #1;
        vectors++;
        if (s_ir !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b want 0", s_ir);
        end
        repeat (2) step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd20 || s_oc !== 4'd2) begin
            errors++;
            $display("FAIL bp_hold: got v=%b d=%h c=%0d want 1/0014/2", s_ov, s_od, s_oc);
        end
        OUT_READY = 1'b1;
        #1;
        vectors++;
        if (s_ir !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", s_ir);
        end
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL bp_consumed: got %b want 0", s_ov);
        end
        drive(1'b1, 16'd40, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd40 || s_oc !== 4'd2) begin
            errors++;
            $display("FAIL bp_next: got v=%b d=%h c=%0d want 1/0028/2", s_ov, s_od, s_oc);
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_window1();
        logic [15:0] d [4];
        logic [3:0]  w [4];
        d[0] = 16'd4; d[1] = 16'd8; d[2] = 16'd1; d[3] = 16'd7;
        w[0] = 4'd1;  w[1] = 4'd1;  w[2] = 4'd1;  w[3] = 4'd0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CFG_WIN_SIZE = w[i];
            drive(1'b1, d[i], 1'b0);
            step();
            vectors++;
            if (s_ov !== 1'b1 || s_od !== d[i] || s_oc !== 4'd1) begin
                errors++;
                $display("FAIL win1 beat%0d: got v=%b d=%h c=%0d want 1/%h/1", i, s_ov, s_od, s_oc, d[i]);
            end
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL win1_drain: got %b want 0", s_ov);
        end
    endtask

    task automatic test_cfg_midwindow();
        CFG_WIN_SIZE = 4'd3;
        drive(1'b1, 16'd5, 1'b0);
        step();
        CFG_WIN_SIZE = 4'd1;
        drive(1'b1, 16'd6, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL cfg_mid_early: got %b want 0", s_ov);
        end
        drive(1'b0, 16'd99, 1'b1);
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL ignored_flush: got %b want 0", s_ov);
        end
        drive(1'b1, 16'd2, 1'b0);
        step();
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd6 || s_oc !== 4'd3) begin
            errors++;
            $display("FAIL cfg_mid_result: got v=%b d=%h c=%0d want 1/0006/3", s_ov, s_od, s_oc);
        end
        drive(1'b0, 16'h0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        logic [15:0] d [4];
        d[0] = 16'd1; d[1] = 16'd1; d[2] = 16'd1; d[3] = 16'd6;
        CFG_WIN_SIZE = 4'd4;
        drive(1'b1, 16'd8, 1'b0);
        step();
        drive(1'b1, 16'd9, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b0);
        RESET = 1'b1;
        #1;
        vectors++;
        if (s_ov !== 1'b0 || s_ir !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b r=%b want 0/0", s_ov, s_ir);
        end
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i], 1'b0);
            step();
            if (i < 3) begin
                vectors++;
                if (s_ov !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_mid_early beat%0d: got %b want 0", i, s_ov);
                end
            end
        end
        vectors++;
        if (s_ov !== 1'b1 || s_od !== 16'd6 || s_oc !== 4'd4) begin
            errors++;
            $display("FAIL rst_mid_result: got v=%b d=%h c=%0d want 1/0006/4", s_ov, s_od, s_oc);
        end
        OUT_READY = 1'b0;
        drive(1'b0, 16'h0, 1'b0);
        step();
        RESET = 1'b1;
        #1;
        vectors++;
        if (s_ov !== 1'b0 || s_od !== 16'h0 || s_oc !== 4'h0) begin
            errors++;
            $display("FAIL rst_pending: got v=%b d=%h c=%h want 0/0000/0", s_ov, s_od, s_oc);
        end
        step();
        RESET = 1'b0;
        OUT_READY = 1'b1;
        step();
        vectors++;
        if (s_ov !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_output: got %b want 0", s_ov);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signedness();
        test_flush();
        test_backpressure();
        test_window1();
        test_cfg_midwindow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
